// File: rtl/dcache_mem.sv
// dcache_mem: quad-SPI SRAM sequencer for dcache line write-back and fill.
// Optional power-up quad-mode entry sequence under `DCACHE_MEM_INIT_EN.
module dcache_mem #(
  parameter int          PA     = 22,
  parameter int          DUMMY  = 4,
  parameter logic [7:0]  CMD_RD = 8'hEB,
  parameter logic [7:0]  CMD_WR = 8'h38
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          access,
  input  logic          fault,
  input  logic          push,
  input  logic          pull,
  input  logic [PA-3:0] tag,
  input  logic [3:0]    dwrite,
  output logic [3:0]    dread,
  output logic          wstrobe_d,
  output logic          rstrobe_d,
  output logic          busy,
  output logic          mem_cs_n,
  output logic          mem_sck_en,
  output logic          mem_oe,
  output logic [3:0]    mem_out,
  input  logic [3:0]    mem_in
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_TURN
  } state_t;

`ifdef DCACHE_MEM_INIT_EN
  localparam state_t RST_ST = S_INIT;
`else
  localparam state_t RST_ST = S_IDLE;
`endif

  localparam logic [3:0] DUMMY_LAST = 4'(DUMMY - 1);
  localparam logic       HAS_DUMMY  = (DUMMY > 0);

  state_t        state;
  state_t        state_nx;
  logic [3:0]    cnt;
  logic          op;
  logic [PA-3:0] a_tag;
  logic [31:0]   sh;
  logic          start;
  logic          last;
  logic [23:0]   addr;

  assign start = (state == S_IDLE) && access && !fault
               && (push || pull);
  assign addr  = {{(24-PA){1'b0}}, tag, 2'b00};

  always_comb begin
    last = 1'b1;
    case (state)
      S_INIT:  last = (cnt == 4'd7);
      S_CMD:   last = (cnt == 4'd1);
      S_ADDR:  last = (cnt == 4'd5);
      S_DUMMY: last = (cnt == DUMMY_LAST);
      S_DATA:  last = (cnt == 4'd7);
      default: last = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RST_ST;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:  if (last) state_nx = S_TURN;
      S_IDLE:  if (start) state_nx = S_CMD;
      S_CMD:   if (last) state_nx = S_ADDR;
      S_ADDR:
        if (last)
          state_nx = (!op && HAS_DUMMY) ? S_DUMMY : S_DATA;
      S_DUMMY: if (last) state_nx = S_DATA;
      S_DATA:  if (last) state_nx = S_TURN;
      S_TURN:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // cnt restarts from zero on every state change
  always_ff @(posedge clk) begin
    if (reset)                 cnt <= 4'd0;
    else if (state_nx != state) cnt <= 4'd0;
    else if (state != S_IDLE)  cnt <= cnt + 4'd1;
  end

  // sh holds {command, address} nibble stream, or the init byte
  always_ff @(posedge clk) begin
    if (reset) begin
      op    <= 1'b0;
      a_tag <= '0;
      sh    <= {8'h35, 24'h0};
    end else if (start) begin
      op    <= push;
      a_tag <= tag;
      sh    <= {push ? CMD_WR : CMD_RD, addr};
    end else if (state == S_INIT) begin
      sh <= {sh[30:0], 1'b0};
    end else if (state == S_CMD || state == S_ADDR) begin
      sh <= {sh[27:0], 4'h0};
    end
  end

  assign dread = mem_in;

  always_comb begin
    wstrobe_d  = 1'b0;
    rstrobe_d  = 1'b0;
    busy       = (state != S_IDLE);
    mem_cs_n   = 1'b1;
    mem_sck_en = 1'b0;
    mem_oe     = 1'b0;
    mem_out    = 4'h0;
    case (state)
      S_INIT: begin
        mem_cs_n   = 1'b0;
        mem_sck_en = 1'b1;
        mem_oe     = 1'b1;
        mem_out    = {3'b000, sh[31]};
      end
      S_CMD, S_ADDR: begin
        mem_cs_n   = 1'b0;
        mem_sck_en = 1'b1;
        mem_oe     = 1'b1;
        mem_out    = sh[31:28];
      end
      S_DUMMY: begin
        mem_cs_n   = 1'b0;
        mem_sck_en = 1'b1;
      end
      S_DATA: begin
        mem_cs_n   = 1'b0;
        mem_sck_en = 1'b1;
        wstrobe_d  = !op;
        rstrobe_d  = op;
        mem_oe     = op;
        mem_out    = op ? dwrite : 4'h0;
      end
      default: ;
    endcase
  end

  logic unused;
  assign unused = ^a_tag;

endmodule
